multi_way_rename_unit: RTL and testbench
========================================

// Module: multi_way_rename_unit
// PURPOSE
//  W-wide register-rename stage for the OOO RISC-V core. Sits in ID, between decode and dispatch.
//  Maps up to RENAME_W arch regs per cycle to physical regs, with same-group dependency bypass.
//  Keeps a speculative map and a committed (retirement) map. Frees old physical regs at commit.
//  On flush, a multi-cycle walk rebuilds the speculative map and the free list from the committed map.
// PARAMETERS
//  ARCH_REG_NUM_WIDTH      5  log2(#arch regs). Arch reg 0 is hardwired x0.
//  PHYSICAL_REG_NUM_WIDTH  6  log2(#physical regs). Must be > ARCH_REG_NUM_WIDTH.
//  RENAME_W                2  rename lanes per cycle (1..4).
//  COMMIT_W                2  commit lanes per cycle (1..4).
// PORTS  (A=ARCH_REG_NUM_WIDTH, P=PHYSICAL_REG_NUM_WIDTH, R=RENAME_W, C=COMMIT_W)
//  clk            in   1     clock. Single clock domain.
//  reset          in   1     synchronous, active-low: state is reset at a clk edge where reset==0.
//  rn_valid       in   R     per-lane instruction valid. Lane 0 is the oldest.
//  rn_regwrite    in   R     lane writes rd.
//  rn_rs1/rn_rs2  in   R*A   source arch regs, packed; lane i is at [i*A +: A].
//  rn_rd          in   R*A   destination arch regs, packed.
//  rn_ready       out  1     whole group can be renamed this cycle.
//  rn_prs1/rn_prs2 out R*P   physical source regs.
//  rn_prd         out  R*P   newly allocated physical dest reg. 0 when there is no allocation.
//  rn_old_prd     out  R*P   previous mapping of rd, carried to the ROB.
//  cm_valid       in   C     commit lane valid. Lane 0 is the oldest.
//  cm_rd          in   C*A   committed arch dest reg.
//  cm_prd         in   C*P   committed physical dest reg.
//  flush          in   1     one-cycle pulse: squash all uncommitted renames.
//  recovering     out  1     walk in progress.
//  free_count     out  P+1   number of free physical regs.
// BEHAVIOUR
//  Reset (reset==0):
//   - spec_map[i] = comm_map[i] = i.
//   - free_vec has bits [2^A, 2^P-1] set; free_count = 2^P-2^A.
//   - state = NORMAL; rn_ready = 0 while reset==0.
//  Ready rule: rn_ready = (state==NORMAL) && (free_count >= R) && !flush.
//   - Independent of the rn_* inputs; there is no comb path from rn_* to rn_ready.
//  Fire: the group renames when rn_ready=1. The outputs are combinational in the same cycle. The maps and free_vec update at the next edge.
//  A lane allocates only if rn_valid && rn_regwrite && rd!=0.
//   - Allocated regs are the lowest-index free bits, taken in lane order.
//   - For a non-allocating lane: rn_prd=0 and rn_old_prd=0.
//  Bypass within a group: lane j's rs1/rs2/old_prd use the youngest earlier lane k<j that allocated for the same rd. Otherwise they use spec_map.
//  Source reg 0 always maps to physical 0.
//  Commit: per lane, in lane order:
//   - old = comm_map[cm_rd], after the effect of earlier lanes in the same cycle.
//   - comm_map[cm_rd] <= cm_prd; set free_vec[old].
//   - cm_rd==0 is ignored.
//   - Freed regs are visible to allocation at the next cycle, not the same cycle.
//  Commit and rename in the same cycle: both apply. free_count_next = free_count - allocs + frees.
//  FSM NORMAL -> RECOVER on flush. Commits in the flush cycle are applied first.
//   - On the flush edge: spec_map <= comm_map_next; free_vec <= all ones; walk idx <= 0.
//   - RECOVER: each cycle, clear free_vec[comm_map[idx]] and increment idx.
//   - When idx == 2^A-1 -> NORMAL. RECOVER lasts exactly 2^A cycles.
//   - In RECOVER: rn_ready=0 and recovering=1. cm_valid must be 0 (bench asserts this).
//   - A flush while in RECOVER restarts the walk at idx 0.
//  free_count is a registered popcount-tracked counter. In RECOVER it counts down as bits are cleared.
//  Invariant in NORMAL: free_count == popcount(free_vec) <= 2^P-2^A.
//  reset==0 in any state, including mid-RECOVER, returns everything to the reset state above.
// STRUCTURE
//  rename_pkg:
//   - localparams ARCH_REGS=2^A and PHYS_REGS=2^P.
//   - typedefs arch_reg_t / phys_reg_t.
//   - enum rn_state_e {RN_NORMAL, RN_RECOVER}.
//  Sub-module free_list_alloc: bit-vector find-first-R priority encoder. Returns R indices plus a per-index valid.
//  The maps are flop arrays. There is no FIFO: the bit-vector free list makes the flush rebuild possible.
// TESTING  (A=5, P=6, R=2, C=2)
//  1. Post-reset, lane0 rd=3 rs1=3, lane1 rd=3 rs1=3:
//     lane0 prs1=3 prd=32 old=3; lane1 prs1=32 prd=33 old=32; free_count 32->30.
//  2. Lane0 rd=0 with regwrite=1: prd=0, old=0, no allocation, free_count unchanged.
//  3. 16 full groups -> free_count=0, rn_ready=0. Then commit rd=3 prd=32 -> regs 3 freed, free_count=1, rn_ready still 0.
//     A second commit rd=3 prd=33 -> free_count=2, rn_ready=1.
//  4. Commit two lanes in one cycle, rd=5 prd=40 and rd=5 prd=41:
//     frees 5 and 40; comm_map[5]=41; free_count +2.
//  5. Rename 4 groups, then flush: recovering=1 for 32 cycles, rn_ready=0.
//     Afterwards rs1=3 -> prs1=comm_map[3], free_count=32, and the next prd is the lowest free reg.
//  6. reset=0 at RECOVER cycle 10:
//     next cycle state=NORMAL, recovering=0, free_count=32, spec_map[i]=i.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and default sizes for the register-rename stage.
package rename_pkg;
  localparam int DEF_ARCH_W = 5;
  localparam int DEF_PHYS_W = 6;
  localparam int ARCH_REGS  = 2 ** DEF_ARCH_W;
  localparam int PHYS_REGS  = 2 ** DEF_PHYS_W;

  typedef logic [DEF_ARCH_W-1:0] arch_reg_t;
  typedef logic [DEF_PHYS_W-1:0] phys_reg_t;

  typedef enum logic {
    RN_NORMAL  = 1'b0,
    RN_RECOVER = 1'b1
  } rn_state_e;
endpackage

// File: rtl/free_list_alloc.sv
// Picks the R lowest-index set bits of the free vector, lowest first.
module free_list_alloc #(
  parameter int P = 6,
  parameter int R = 2
) (
  input  logic [2**P-1:0] free_vec,
  output logic [R*P-1:0]  idx,
  output logic [R-1:0]    found
);
  always_comb begin
    logic [2**P-1:0] remaining;
    logic [P-1:0]    sel;
    logic            hit;
    remaining = free_vec;
    idx       = '0;
    found     = '0;
    sel       = '0;
    hit       = 1'b0;
    for (int r = 0; r < R; r++) begin
      sel = '0;
      hit = 1'b0;
      // Scanning downward leaves the lowest set bit as the final pick.
      for (int b = 2**P - 1; b >= 0; b--) begin
        if (remaining[b]) begin
          sel = P'(b);
          hit = 1'b1;
        end
      end
      if (hit) remaining[sel] = 1'b0;
      idx[r*P +: P] = sel;
      found[r]      = hit;
    end
  end
endmodule

// File: rtl/multi_way_rename_unit.sv
// Multi-lane register rename with speculative/committed maps, a bit-vector
// free list, and a walk that rebuilds the free list after a flush.
module multi_way_rename_unit
  import rename_pkg::*;
#(
  parameter int ARCH_REG_NUM_WIDTH     = 5,
  parameter int PHYSICAL_REG_NUM_WIDTH = 6,
  parameter int RENAME_W               = 2,
  parameter int COMMIT_W               = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [RENAME_W-1:0]                    rn_valid,
  input  logic [RENAME_W-1:0]                    rn_regwrite,
  input  logic [RENAME_W*ARCH_REG_NUM_WIDTH-1:0] rn_rs1,
  input  logic [RENAME_W*ARCH_REG_NUM_WIDTH-1:0] rn_rs2,
  input  logic [RENAME_W*ARCH_REG_NUM_WIDTH-1:0] rn_rd,
  output logic                                   rn_ready,
  output logic [RENAME_W*PHYSICAL_REG_NUM_WIDTH-1:0] rn_prs1,
  output logic [RENAME_W*PHYSICAL_REG_NUM_WIDTH-1:0] rn_prs2,
  output logic [RENAME_W*PHYSICAL_REG_NUM_WIDTH-1:0] rn_prd,
  output logic [RENAME_W*PHYSICAL_REG_NUM_WIDTH-1:0] rn_old_prd,
  input  logic [COMMIT_W-1:0]                    cm_valid,
  input  logic [COMMIT_W*ARCH_REG_NUM_WIDTH-1:0] cm_rd,
  input  logic [COMMIT_W*PHYSICAL_REG_NUM_WIDTH-1:0] cm_prd,
  input  logic                                   flush,
  output logic                                   recovering,
  output logic [PHYSICAL_REG_NUM_WIDTH:0]        free_count,
  output rn_state_e                              state
);
  localparam int A  = ARCH_REG_NUM_WIDTH;
  localparam int P  = PHYSICAL_REG_NUM_WIDTH;
  localparam int R  = RENAME_W;
  localparam int C  = COMMIT_W;
  localparam int NA = 2 ** A;
  localparam int NP = 2 ** P;

  rn_state_e      state_next;
  logic [P-1:0]   spec_map  [NA];
  logic [P-1:0]   comm_map  [NA];
  logic [P-1:0]   comm_next [NA];
  logic [NP-1:0]  free_vec, alloc_clr, commit_set;
  logic [A-1:0]   walk_idx;
  logic [R*P-1:0] cand_idx;
  logic [R-1:0]   cand_found, lane_alloc;
  logic [P:0]     alloc_cnt, free_cnt_inc;
  logic           fire;

  // Handshake: the group is consumed on any cycle where rn_ready is high; rn_ready
  // never looks at rn_* so the decoder may hold or change the group freely.
  assign rn_ready   = reset && (state == RN_NORMAL) && (free_count >= (P+1)'(R)) && !flush;
  assign fire       = rn_ready;
  assign recovering = (state == RN_RECOVER);

  free_list_alloc #(.P(P), .R(R)) u_alloc (
    .free_vec (free_vec),
    .idx      (cand_idx),
    .found    (cand_found)
  );

  always_comb begin
    logic [R-1:0] alloc_l;
    logic [P-1:0] prd_l [R];
    logic [A-1:0] rd, rs1, rs2, rd_k;
    logic [P-1:0] p1, p2, po, pn;
    int           slot;
    alloc_l = '0;
    slot = 0;
    rd = '0; rs1 = '0; rs2 = '0; rd_k = '0;
    p1 = '0; p2 = '0; po = '0; pn = '0;
    for (int j = 0; j < R; j++) prd_l[j] = '0;
    alloc_clr  = '0;
    rn_prs1    = '0;
    rn_prs2    = '0;
    rn_prd     = '0;
    rn_old_prd = '0;
    for (int j = 0; j < R; j++) begin
      rd  = rn_rd[j*A +: A];
      rs1 = rn_rs1[j*A +: A];
      rs2 = rn_rs2[j*A +: A];
      p1  = spec_map[rs1];
      p2  = spec_map[rs2];
      po  = spec_map[rd];
      // Ascending scan so the youngest earlier producer wins.
      for (int k = 0; k < j; k++) begin
        rd_k = rn_rd[k*A +: A];
        if (alloc_l[k] && rd_k == rs1) p1 = prd_l[k];
        if (alloc_l[k] && rd_k == rs2) p2 = prd_l[k];
        if (alloc_l[k] && rd_k == rd)  po = prd_l[k];
      end
      if (rs1 == '0) p1 = '0;
      if (rs2 == '0) p2 = '0;
      if (rn_valid[j] && rn_regwrite[j] && rd != '0) begin
        alloc_l[j] = 1'b1;
        pn = cand_idx[slot*P +: P];
        if (fire && cand_found[slot]) alloc_clr[pn] = 1'b1;
        slot = slot + 1;
        prd_l[j] = pn;
        rn_prd[j*P +: P]     = pn;
        rn_old_prd[j*P +: P] = po;
      end
      rn_prs1[j*P +: P] = p1;
      rn_prs2[j*P +: P] = p2;
    end
    lane_alloc = alloc_l;
    alloc_cnt  = fire ? (P+1)'(slot) : '0;
  end

  always_comb begin
    logic [A-1:0] crd;
    logic [P-1:0] old_p;
    crd          = '0;
    old_p        = '0;
    comm_next    = comm_map;
    commit_set   = '0;
    free_cnt_inc = '0;
    for (int c = 0; c < C; c++) begin
      crd = cm_rd[c*A +: A];
      if (cm_valid[c] && crd != '0 && state == RN_NORMAL) begin
        old_p            = comm_next[crd];
        commit_set[old_p] = 1'b1;
        comm_next[crd]   = cm_prd[c*P +: P];
        free_cnt_inc     = free_cnt_inc + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RN_NORMAL:  if (flush) state_next = RN_RECOVER;
      RN_RECOVER: if (!flush && walk_idx == A'(NA - 1)) state_next = RN_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RN_NORMAL;
      walk_idx   <= '0;
      free_count <= (P+1)'(NP - NA);
      free_vec   <= {{(NP-NA){1'b1}}, {NA{1'b0}}};
      for (int i = 0; i < NA; i++) begin
        spec_map[i] <= P'(i);
        comm_map[i] <= P'(i);
      end
    end else begin
      state    <= state_next;
      comm_map <= comm_next;
      if (flush) begin
        // Start from all-free; the walk then claims every committed mapping.
        spec_map   <= comm_next;
        free_vec   <= '1;
        free_count <= (P+1)'(NP);
        walk_idx   <= '0;
      end else if (state == RN_RECOVER) begin
        free_vec[comm_map[walk_idx]] <= 1'b0;
        free_count <= free_count - 1'b1;
        walk_idx   <= walk_idx + 1'b1;
      end else begin
        free_vec   <= (free_vec & ~alloc_clr) | commit_set;
        free_count <= free_count - alloc_cnt + free_cnt_inc;
        for (int j = 0; j < R; j++) begin
          if (fire && lane_alloc[j]) spec_map[rn_rd[j*A +: A]] <= rn_prd[j*P +: P];
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_way_rename_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a map/free-set model.
module tb_multi_way_rename_unit;
  import rename_pkg::*;
  localparam int A = 5, P = 6, R = 2, C = 2, NA = 32, NP = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [R-1:0]   rn_valid, rn_regwrite;
  logic [R*A-1:0] rn_rs1, rn_rs2, rn_rd;
  logic           rn_ready;
  logic [R*P-1:0] rn_prs1, rn_prs2, rn_prd, rn_old_prd;
  logic [C-1:0]   cm_valid;
  logic [C*A-1:0] cm_rd;
  logic [C*P-1:0] cm_prd;
  logic           flush, recovering;
  logic [P:0]     free_count;
  rn_state_e      state;

  always #5 clk = ~clk;

  multi_way_rename_unit dut (
    .clk(clk), .reset(reset),
    .rn_valid(rn_valid), .rn_regwrite(rn_regwrite),
    .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd),
    .rn_ready(rn_ready), .rn_prs1(rn_prs1), .rn_prs2(rn_prs2),
    .rn_prd(rn_prd), .rn_old_prd(rn_old_prd),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_prd(cm_prd),
    .flush(flush), .recovering(recovering), .free_count(free_count), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural maps, set of free regs, walk progress.
  phys_reg_t spec_m [NA];
  phys_reg_t comm_m [NA];
  bit        free_m [NP];
  bit        rec_m;
  int        rec_k;
  // Renamed-but-uncommitted destinations {rd, prd}, oldest first.
  logic [A+P-1:0] exp_q [$];

  always @(posedge clk) begin
    if (reset && recovering) assert (cm_valid == '0) else $error("cm_valid asserted during recovery");
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_free_count();
    int n = 0;
    if (rec_m) return NP - rec_k;
    for (int p = 0; p < NP; p++) n += int'(free_m[p]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      spec_m[i] = phys_reg_t'(i);
      comm_m[i] = phys_reg_t'(i);
    end
    for (int p = 0; p < NP; p++) free_m[p] = (p >= NA);
    rec_m = 1'b0;
    rec_k = 0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    rn_valid = '0; rn_regwrite = '0; rn_rs1 = '0; rn_rs2 = '0; rn_rd = '0;
    cm_valid = '0; cm_rd = '0; cm_prd = '0; flush = 1'b0;
  endtask

  task automatic set_lane(input int j, input bit v, input bit w, input int rd, input int rs1, input int rs2);
    rn_valid[j]       = v;
    rn_regwrite[j]    = w;
    rn_rd[j*A +: A]   = A'(rd);
    rn_rs1[j*A +: A]  = A'(rs1);
    rn_rs2[j*A +: A]  = A'(rs2);
  endtask

  task automatic set_commit(input int c, input int rd, input int prd);
    cm_valid[c]       = 1'b1;
    cm_rd[c*A +: A]   = A'(rd);
    cm_prd[c*P +: P]  = P'(prd);
  endtask

  task automatic commit_from_q(input int n);
    logic [A-1:0] crd;
    logic [P-1:0] cprd;
    for (int c = 0; c < n && c < C; c++) begin
      if (exp_q.size() > 0) begin
        {crd, cprd} = exp_q.pop_front();
        set_commit(c, int'(crd), int'(cprd));
      end
    end
  endtask

  // Called just after a negedge with inputs driven; checks, advances model, returns after next negedge.
  task automatic cycle();
    phys_reg_t tmp [NA];
    bit  taken [NP];
    bit  exp_ready;
    int  fc, rd, rs1, rs2, e1, e2, ep, eo;
    #1;
    if (reset === 1'b0) begin
      check("ready_in_reset", 32'(rn_ready), 0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      clear_inputs();
      return;
    end
    fc = model_free_count();
    exp_ready = !rec_m && fc >= R && !flush;
    check("rn_ready", 32'(rn_ready), 32'(exp_ready));
    check("free_count", 32'(free_count), fc);
    check("recovering", 32'(recovering), 32'(rec_m));
    tmp = spec_m;
    for (int j = 0; j < R; j++) begin
      rd  = int'(rn_rd[j*A +: A]);
      rs1 = int'(rn_rs1[j*A +: A]);
      rs2 = int'(rn_rs2[j*A +: A]);
      e1  = (rs1 == 0) ? 0 : int'(tmp[rs1]);
      e2  = (rs2 == 0) ? 0 : int'(tmp[rs2]);
      ep  = 0;
      eo  = 0;
      if (rn_valid[j] && rn_regwrite[j] && rd != 0) begin
        eo = int'(tmp[rd]);
        for (int p = 0; p < NP; p++) begin
          if (free_m[p] && !taken[p]) begin
            ep = p;
            break;
          end
        end
        taken[ep] = 1'b1;
        tmp[rd]   = phys_reg_t'(ep);
        if (exp_ready) exp_q.push_back({A'(rd), P'(ep)});
      end
      if (exp_ready) begin
        check($sformatf("lane%0d_prs1", j), 32'(rn_prs1[j*P +: P]), e1);
        check($sformatf("lane%0d_prs2", j), 32'(rn_prs2[j*P +: P]), e2);
        check($sformatf("lane%0d_prd", j), 32'(rn_prd[j*P +: P]), ep);
        check($sformatf("lane%0d_old_prd", j), 32'(rn_old_prd[j*P +: P]), eo);
      end
    end
    if (exp_ready) begin
      spec_m = tmp;
      for (int p = 0; p < NP; p++) if (taken[p]) free_m[p] = 1'b0;
    end
    if (!rec_m) begin
      for (int c = 0; c < C; c++) begin
        rd = int'(cm_rd[c*A +: A]);
        if (cm_valid[c] && rd != 0) begin
          free_m[comm_m[rd]] = 1'b1;
          comm_m[rd] = cm_prd[c*P +: P];
        end
      end
    end
    if (flush) begin
      rec_m  = 1'b1;
      rec_k  = 0;
      spec_m = comm_m;
      for (int p = 0; p < NP; p++) free_m[p] = 1'b1;
      for (int i = 0; i < NA; i++) free_m[comm_m[i]] = 1'b0;
      exp_q.delete();
    end else if (rec_m) begin
      rec_k++;
      if (rec_k == NA) rec_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    int n_rec;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // 1: same-group bypass right after reset
    do_reset();
    #1;
    check("reset_free_count", 32'(free_count), 32);
    check("reset_recovering", 32'(recovering), 0);
    check("reset_state", 32'(state), 32'(RN_NORMAL));
    set_lane(0, 1, 1, 3, 3, 0);
    set_lane(1, 1, 1, 3, 3, 0);
    #1;
    check("t1_l0_prs1", 32'(rn_prs1[5:0]), 3);
    check("t1_l0_prd", 32'(rn_prd[5:0]), 32);
    check("t1_l0_old", 32'(rn_old_prd[5:0]), 3);
    check("t1_l1_prs1", 32'(rn_prs1[11:6]), 32);
    check("t1_l1_prd", 32'(rn_prd[11:6]), 33);
    check("t1_l1_old", 32'(rn_old_prd[11:6]), 32);
    cycle();
    check("t1_free_count", 32'(free_count), 30);

    // 2: rd=0 never allocates
    set_lane(0, 1, 1, 0, 4, 7);
    #1;
    check("t2_prd", 32'(rn_prd[5:0]), 0);
    check("t2_old", 32'(rn_old_prd[5:0]), 0);
    cycle();
    check("t2_free_count", 32'(free_count), 30);

    // 3: exhaust the free list, then commits release it
    do_reset();
    repeat (16) begin
      set_lane(0, 1, 1, 3, 3, 0);
      set_lane(1, 1, 1, 3, 3, 0);
      cycle();
    end
    check("t3_empty_count", 32'(free_count), 0);
    check("t3_empty_ready", 32'(rn_ready), 0);
    commit_from_q(1);
    cycle();
    check("t3_one_count", 32'(free_count), 1);
    check("t3_one_ready", 32'(rn_ready), 0);
    commit_from_q(1);
    cycle();
    check("t3_two_count", 32'(free_count), 2);
    check("t3_two_ready", 32'(rn_ready), 1);

    // 4: two commits to the same rd in one cycle
    do_reset();
    repeat (4) begin
      set_lane(0, 1, 1, 1, 2, 0);
      set_lane(1, 1, 1, 1, 1, 0);
      cycle();
    end
    set_lane(0, 1, 1, 5, 0, 0);
    set_lane(1, 1, 1, 5, 5, 0);
    cycle();
    check("t4_before", 32'(free_count), 22);
    set_commit(0, 5, 40);
    set_commit(1, 5, 41);
    cycle();
    check("t4_after", 32'(free_count), 24);

    // 5: flush and the 32-cycle walk
    repeat (4) begin
      set_lane(0, 1, 1, 2, 1, 5);
      set_lane(1, 1, 1, 2, 2, 0);
      cycle();
    end
    flush = 1'b1;
    cycle();
    n_rec = 0;
    for (int i = 0; i < 40 && recovering; i++) begin
      cycle();
      n_rec++;
    end
    check("t5_recover_cycles", n_rec, 32);
    set_lane(0, 1, 1, 7, 5, 3);
    #1;
    check("t5_prs1", 32'(rn_prs1[5:0]), 41);
    check("t5_prs2", 32'(rn_prs2[5:0]), 3);
    check("t5_prd", 32'(rn_prd[5:0]), 5);
    check("t5_free_count", 32'(free_count), 32);
    cycle();

    // 6: reset in the middle of the walk
    flush = 1'b1;
    cycle();
    repeat (10) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    check("t6_recovering", 32'(recovering), 0);
    check("t6_state", 32'(state), 32'(RN_NORMAL));
    check("t6_free_count", 32'(free_count), 32);
    set_lane(0, 1, 0, 0, 5, 9);
    #1;
    check("t6_prs1", 32'(rn_prs1[5:0]), 5);
    check("t6_prs2", 32'(rn_prs2[5:0]), 9);
    cycle();

    // Random traffic with in-order commits and occasional flushes
    do_reset();
    repeat (2000) begin
      for (int j = 0; j < R; j++)
        set_lane(j, bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if (!rec_m && $urandom_range(0, 2) != 0) commit_from_q($urandom_range(1, 2));
      if ($urandom_range(0, 79) == 0) flush = 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
